// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: req/gnt/rvalid memory port bundle shared by cores, arbiter and memory.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              req;
   logic              gnt;
   logic              rvalid;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [DATA_W/8-1:0] be;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin 2:1 arbiter onto one memory port, rvalid routed back through an in-order ID queue.
// Defining MEM_ARB_PERF_CNT_EN adds per-master grant counters and a conflict-cycle counter.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   mem_port_arbiter_if.slave  m0,
   mem_port_arbiter_if.slave  m1,
   mem_port_arbiter_if.master mem,
`ifdef MEM_ARB_PERF_CNT_EN
   output logic [31:0]        gnt_cnt0_o,
   output logic [31:0]        gnt_cnt1_o,
   output logic [31:0]        conflict_cnt_o,
`endif
   output logic               rsp_err_o
);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   logic          id_q [MAX_OUTSTANDING];
   logic          id_d [MAX_OUTSTANDING];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rr_q, rr_d, lock_q, lock_d, lock_id_q, lock_id_d, err_q, err_d;
   logic          full, elig0, elig1, sel, mux_sel, mem_req, acc, pop, head;
   logic [ADDR_W-1:0]   addr_mux;
   logic [DATA_W/8-1:0] be_mux;
   logic [DATA_W-1:0]   wdata_mux;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      // Outputs are forced quiet while reset is held, regardless of master inputs.
      full      = cnt_q == CW'(MAX_OUTSTANDING);
      elig0     = rst_ni & m0.req & ~full;
      elig1     = rst_ni & m1.req & ~full;
      sel       = lock_q ? lock_id_q : (elig0 ^ elig1) ? elig1 : rr_q;
      mem_req   = sel ? elig1 : elig0;
      mux_sel   = mem_req & sel;
      addr_mux  = mux_sel ? m1.addr : m0.addr;
      be_mux    = mux_sel ? m1.be : m0.be;
      wdata_mux = mux_sel ? m1.wdata : m0.wdata;
      acc       = mem_req & mem.gnt;
      pop       = mem.rvalid & (cnt_q != '0);
      head      = id_q[rd_q];
      id_d      = id_q;
      if (acc) id_d[wr_q] = sel;
      wr_d      = acc ? nxt(wr_q) : wr_q;
      rd_d      = pop ? nxt(rd_q) : rd_q;
      cnt_d     = cnt_q + CW'(acc) - CW'(pop);
      rr_d      = acc ? ~sel : rr_q;
      lock_d    = mem_req & ~mem.gnt;
      lock_id_d = sel;
      err_d     = err_q | (mem.rvalid & (cnt_q == '0));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= 1'b0;
         rd_q      <= '0;
         wr_q      <= '0;
         cnt_q     <= '0;
         rr_q      <= 1'b0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         id_q      <= id_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
         rr_q      <= rr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         err_q     <= err_d;
      end
   end

   assign mem.req    = mem_req;
   assign mem.addr   = addr_mux;
   assign mem.we     = mux_sel ? m1.we : m0.we;
   assign mem.be     = be_mux;
   assign mem.wdata  = wdata_mux;
   assign m0.gnt     = acc & ~sel;
   assign m1.gnt     = acc & sel;
   assign m0.rvalid  = pop & ~head;
   assign m1.rvalid  = pop & head;
   assign m0.rdata   = mem.rdata;
   assign m1.rdata   = mem.rdata;
   assign rsp_err_o  = err_q;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d, conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      gnt_cnt0_d     = gnt_cnt0_q + 32'(acc & ~sel);
      gnt_cnt1_d     = gnt_cnt1_q + 32'(acc & sel);
      conflict_cnt_d = conflict_cnt_q + 32'(m0.req & m1.req);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt_cnt0_q     <= '0;
         gnt_cnt1_q     <= '0;
         conflict_cnt_q <= '0;
      end else begin
         gnt_cnt0_q     <= gnt_cnt0_d;
         gnt_cnt1_q     <= gnt_cnt1_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign gnt_cnt0_o     = gnt_cnt0_q;
   assign gnt_cnt1_o     = gnt_cnt1_q;
   assign conflict_cnt_o = conflict_cnt_q;
`endif
endmodule
